// File: rtl/keypad_pkg.sv
// Shared types and lookup helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_EVAL
  } scan_state_e;

  localparam logic [3:0] COL_IDLE  = 4'b1111;
  localparam logic [7:0] KEY_CLEAR = 8'h01;

  // Column 0 drives the MSB low, column 3 the LSB.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = 4'b0111;
      2'd1:    col_drive = 4'b1011;
      2'd2:    col_drive = 4'b1101;
      default: col_drive = 4'b1110;
    endcase
  endfunction

  function automatic logic [7:0] code_to_ascii(input logic [3:0] code);
    case (code)
      4'd0:    code_to_ascii = "1";
      4'd1:    code_to_ascii = "4";
      4'd2:    code_to_ascii = "7";
      4'd3:    code_to_ascii = "0";
      4'd4:    code_to_ascii = "2";
      4'd5:    code_to_ascii = "5";
      4'd6:    code_to_ascii = "8";
      4'd7:    code_to_ascii = KEY_CLEAR;
      4'd8:    code_to_ascii = "3";
      4'd9:    code_to_ascii = "6";
      4'd10:   code_to_ascii = "9";
      4'd11:   code_to_ascii = "=";
      4'd12:   code_to_ascii = "+";
      4'd13:   code_to_ascii = "-";
      4'd14:   code_to_ascii = "*";
      default: code_to_ascii = "/";
    endcase
  endfunction

  function automatic logic [3:0] onehot_index(input logic [15:0] img);
    onehot_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (img[i]) onehot_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag for dropped pushes.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             valid_q;
  logic             overflow_q;
  logic             full, do_pop, do_push, drop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && valid_q;
  assign do_push = push_i && (!full || do_pop);
  assign drop    = push_i && full && !do_pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the head is masked by valid, so stale entries never leak out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o     = valid_q ? mem_q[rd_ptr_q] : '0;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scan sequencer with whole-image debounce; one event per clean single-key press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC     = 10,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [DW-1:0] STAB_MAX    = DW'(DEBOUNCE_SCANS);

  scan_state_e   state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   cur_img_q, cur_img_d;
  logic [15:0]   cand_img_q, cand_img_d;
  logic [15:0]   deb_img_q, deb_img_d;
  logic [DW-1:0] stab_q, stab_d;
  logic          push;
  logic [11:0]   push_data;
  logic [11:0]   head;

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    settle_d   = settle_q;
    col_d      = col_q;
    cur_img_d  = cur_img_q;
    cand_img_d = cand_img_q;
    deb_img_d  = deb_img_q;
    stab_d     = stab_q;
    push       = 1'b0;
    push_data  = '0;

    case (state_q)
      ST_DRIVE: begin
        col_d    = col_drive(col_idx_q);
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d  = ST_SAMPLE;
        else                         settle_d = settle_q + SW'(1);
      end
      ST_SAMPLE: begin
        // Bit col*4+r holds row r; row[3] is physical row 0.
        cur_img_d[{col_idx_q, 2'b00} +: 4] = ~{row[0], row[1], row[2], row[3]};
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (col_idx_q == 2'd3) begin
          state_d = ST_EVAL;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_DRIVE;
        end
      end
      ST_EVAL: begin
        col_idx_d = 2'd0;
        state_d   = ST_DRIVE;
        if (cur_img_q == cand_img_q) begin
          if (stab_q != STAB_MAX) stab_d = stab_q + DW'(1);
        end else begin
          cand_img_d = cur_img_q;
          stab_d     = DW'(1);
        end
        // Only a fresh single key out of a fully released image is an event.
        if (stab_d == STAB_MAX && stab_q != STAB_MAX) begin
          deb_img_d = cand_img_d;
          if ($countones(cand_img_d) == 1 && deb_img_q == '0) begin
            push      = 1'b1;
            push_data = {onehot_index(cand_img_d), code_to_ascii(onehot_index(cand_img_d))};
          end
        end
      end
      default: state_d = ST_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DRIVE;
      col_idx_q  <= 2'd0;
      settle_q   <= '0;
      col_q      <= COL_IDLE;
      cur_img_q  <= '0;
      cand_img_q <= '0;
      deb_img_q  <= '0;
      stab_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      settle_q   <= settle_d;
      col_q      <= col_d;
      cur_img_q  <= cur_img_d;
      cand_img_q <= cand_img_d;
      deb_img_q  <= deb_img_d;
      stab_q     <= stab_d;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (12)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .data_i     (push_data),
    .pop_i      (key_ready),
    .data_o     (head),
    .valid_o    (key_valid),
    .overflow_o (overflow)
  );

  assign col                   = col_q;
  assign {key_code, key_ascii} = head;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench: a keypad matrix model driven by col, with hand-computed expected events.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;

  logic [15:0] pressed;
  int          checks   = 0;
  int          failures = 0;
  int          valid_cyc;
  logic [3:0]  ev_code [$];
  logic [7:0]  ev_ascii [$];

  always #5 clk = ~clk;

  keypad_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_ascii (key_ascii),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  // Pressed key at col c, row r pulls row[3-r] low while column c is driven.
  always_comb begin
    int base;
    base = -1;
    row  = 4'b1111;
    case (col)
      4'b0111: base = 0;
      4'b1011: base = 4;
      4'b1101: base = 8;
      4'b1110: base = 12;
      default: base = -1;
    endcase
    if (base >= 0)
      row = ~{pressed[base], pressed[base+1], pressed[base+2], pressed[base+3]};
  end

  always @(negedge clk) begin
    if (key_valid) valid_cyc++;
    if (key_valid && key_ready) begin
      ev_code.push_back(key_code);
      ev_ascii.push_back(key_ascii);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after col switches to column 0, i.e. at the start of a new scan.
  task automatic next_scan();
    logic [3:0] prev;
    logic       tmo;
    prev = col;
    tmo  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (col == 4'b0111 && prev != 4'b0111) begin
        tmo = 1'b0;
        break;
      end
      prev = col;
    end
    check("scan_timeout", {31'd0, tmo}, 32'd0);
  endtask

  task automatic scans(input int n);
    for (int i = 0; i < n; i++) next_scan();
  endtask

  task automatic clear_events();
    ev_code.delete();
    ev_ascii.delete();
  endtask

  logic [3:0] exp_codes [5] = '{4'd0, 4'd4, 4'd8, 4'd1, 4'd5};
  logic [7:0] exp_asc   [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

  initial begin
    rst       = 1'b1;
    key_ready = 1'b0;
    pressed   = '0;
    valid_cyc = 0;
    repeat (3) tick();
    check("rst_col", {28'd0, col}, 32'hF);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_ascii", {24'd0, key_ascii}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    check("first_drive_col", {28'd0, col}, 32'h7);

    // Hold "5" for 8 scans: pushed in the EVAL of the 4th scan.
    key_ready = 1'b1;
    clear_events();
    valid_cyc = 0;
    pressed   = 16'h1 << 5;
    scans(3);
    check("k5_early", ev_code.size(), 0);
    next_scan();
    check("k5_count", ev_code.size(), 1);
    if (ev_code.size() > 0) begin
      check("k5_code", {28'd0, ev_code[0]}, 32'd5);
      check("k5_ascii", {24'd0, ev_ascii[0]}, 32'h35);
    end
    scans(4);
    check("k5_norepeat", ev_code.size(), 1);
    check("k5_valid_cyc", valid_cyc, 1);
    pressed = '0;
    scans(5);

    // "F" is the clear key at col1 row3.
    clear_events();
    pressed = 16'h1 << 7;
    scans(5);
    check("kF_count", ev_code.size(), 1);
    if (ev_code.size() > 0) begin
      check("kF_code", {28'd0, ev_code[0]}, 32'd7);
      check("kF_ascii", {24'd0, ev_ascii[0]}, 32'h01);
    end
    pressed = '0;
    scans(5);

    // Bouncing "9": pressed, released, then held; 4 stable EVALs needed.
    clear_events();
    pressed = 16'h1 << 10;
    next_scan();
    pressed = '0;
    next_scan();
    pressed = 16'h1 << 10;
    scans(3);
    check("k9_early", ev_code.size(), 0);
    next_scan();
    check("k9_count", ev_code.size(), 1);
    if (ev_code.size() > 0) begin
      check("k9_code", {28'd0, ev_code[0]}, 32'd10);
      check("k9_ascii", {24'd0, ev_ascii[0]}, 32'h39);
    end
    scans(2);
    check("k9_norepeat", ev_code.size(), 1);
    pressed = '0;
    scans(5);

    // Two keys at once never produce an event; a later single key does.
    clear_events();
    pressed = (16'h1 << 0) | (16'h1 << 12);
    scans(10);
    check("ghost_none", ev_code.size(), 0);
    pressed = '0;
    scans(5);
    pressed = 16'h1 << 15;
    scans(5);
    check("kD_count", ev_code.size(), 1);
    if (ev_code.size() > 0) begin
      check("kD_code", {28'd0, ev_code[0]}, 32'd15);
      check("kD_ascii", {24'd0, ev_ascii[0]}, 32'h2F);
    end
    pressed = '0;
    scans(5);

    // Five presses with no consumer: four queued, fifth dropped.
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pressed = 16'h1 << exp_codes[k];
      scans(5);
      pressed = '0;
      scans(5);
      if (k == 3) begin
        check("ovf_at_full", {31'd0, overflow}, 32'd0);
        check("valid_queued", {31'd0, key_valid}, 32'd1);
      end
    end
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_valid", {31'd0, key_valid}, 32'd1);
    check("ovf_head_code", {28'd0, key_code}, 32'd0);
    check("ovf_head_ascii", {24'd0, key_ascii}, 32'h31);
    clear_events();
    key_ready = 1'b1;
    repeat (10) tick();
    check("drain_count", ev_code.size(), 4);
    for (int i = 0; i < 4 && i < ev_code.size(); i++) begin
      check($sformatf("drain_code%0d", i), {28'd0, ev_code[i]}, {28'd0, exp_codes[i]});
      check($sformatf("drain_ascii%0d", i), {24'd0, ev_ascii[i]}, {24'd0, exp_asc[i]});
    end
    check("drain_empty", {31'd0, key_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Queue two events, then reset mid-SETTLE while "7" is still held.
    key_ready = 1'b0;
    pressed   = 16'h1 << 6;
    scans(5);
    pressed = '0;
    scans(5);
    pressed = 16'h1 << 2;
    scans(5);
    check("pre_rst_valid", {31'd0, key_valid}, 32'd1);
    check("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_col", {28'd0, col}, 32'hF);
    rst       = 1'b0;
    key_ready = 1'b1;
    clear_events();
    tick();
    check("post_rst_col", {28'd0, col}, 32'h7);
    scans(5);
    check("held_count", ev_code.size(), 1);
    if (ev_code.size() > 0) begin
      check("held_code", {28'd0, ev_code[0]}, 32'd2);
      check("held_ascii", {24'd0, ev_ascii[0]}, 32'h37);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
